// File: rtl/sar_search.sv
// Successive-approximation search engine driving one operand of a magnitude comparator.
// Optional macro SAR_ONEHOT_CHECK_EN enables the comparator flag one-hot protocol check (err).
module sar_search #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW-1:0]    TOP_IDX  = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, TRY, VERIFY} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] next_guess;
  logic             flags_bad;

`ifdef SAR_ONEHOT_CHECK_EN
  assign flags_bad = !$onehot({cmp_gt, cmp_lt, cmp_eq});
`else
  assign flags_bad = 1'b0;
  assign err       = 1'b0;
`endif

  // Resolve the current bit (lt beats gt; no flags at all counts as gt) and arm the next one.
  always_comb begin
    next_guess = guess;
    casez ({cmp_lt, cmp_gt})
      2'b1?:   next_guess[idx] = 1'b0;
      2'b01:   next_guess[idx] = 1'b1;
      default: next_guess[idx] = 1'b1;
    endcase
    if (idx != '0)
      next_guess[idx - 1'b1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      guess  <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      result <= '0;
`ifdef SAR_ONEHOT_CHECK_EN
      err    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            guess <= MSB_ONLY;
            idx   <= TOP_IDX;
            busy  <= 1'b1;
            found <= 1'b0;
`ifdef SAR_ONEHOT_CHECK_EN
            err   <= 1'b0;
`endif
            state <= TRY;
          end
        end
        TRY: begin
          if (flags_bad || cmp_eq) begin
            result <= guess;
            found  <= !flags_bad;
            done   <= 1'b1;
            busy   <= 1'b0;
`ifdef SAR_ONEHOT_CHECK_EN
            err    <= flags_bad;
`endif
            state  <= IDLE;
          end else begin
            guess <= next_guess;
            if (idx != '0)
              idx <= idx - 1'b1;
            else
              state <= VERIFY;
          end
        end
        VERIFY: begin
          result <= guess;
          found  <= cmp_eq && !flags_bad;
          done   <= 1'b1;
          busy   <= 1'b0;
`ifdef SAR_ONEHOT_CHECK_EN
          err    <= flags_bad;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search (WIDTH=3) with a behavioural comparator that can be overridden.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] guess;
  logic       cmp_gt, cmp_lt, cmp_eq;
  logic       busy, done, found, err;
  logic [2:0] result;

  logic [2:0] target;
  int         mode;
  int         checks = 0;
  int         errors = 0;

  sar_search #(.WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .guess(guess),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .busy(busy), .done(done), .found(found), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  // Mode 0 is a true comparator; 1 is stuck at gt; 2 drives the illegal pattern 011.
  always_comb begin
    case (mode)
      1:       {cmp_gt, cmp_lt, cmp_eq} = 3'b100;
      2:       {cmp_gt, cmp_lt, cmp_eq} = 3'b011;
      default: {cmp_gt, cmp_lt, cmp_eq} = {target > guess, target < guess, target == guess};
    endcase
  end

  task automatic applyStimulus(input logic s, input logic r);
    start = s;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    start = 1'b0; rst = 1'b1; target = 3'd0; mode = 0;
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_guess", guess, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_found_err", {found, err}, 0);

    $display("[TB] target 5");
    target = 3'd5;
    applyStimulus(1, 0);
    checkOutput("t5_e0_guess", guess, 3'b100);
    checkOutput("t5_e0_busy", busy, 1);
    applyStimulus(0, 0);
    checkOutput("t5_e1_guess", guess, 3'b110);
    applyStimulus(0, 0);
    checkOutput("t5_e2_guess", guess, 3'b101);
    checkOutput("t5_e2_done", done, 0);
    applyStimulus(0, 0);
    checkOutput("t5_e3_done_busy", {done, busy}, 2'b10);
    checkOutput("t5_e3_found", found, 1);
    checkOutput("t5_e3_result", result, 3'b101);
    applyStimulus(0, 0);
    checkOutput("t5_e4_done_low", done, 0);
    checkOutput("t5_e4_found_held", {found, result}, {1'b1, 3'b101});

    $display("[TB] target 4 early match");
    target = 3'd4;
    applyStimulus(1, 0);
    checkOutput("t4_e0_busy", busy, 1);
    applyStimulus(0, 0);
    checkOutput("t4_e1_done_busy", {done, busy}, 2'b10);
    checkOutput("t4_e1_found_result", {found, result}, {1'b1, 3'b100});

    $display("[TB] target 0 with ignored start while busy");
    target = 3'd0;
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    checkOutput("t0_e1_guess", guess, 3'b010);
    applyStimulus(0, 0);
    checkOutput("t0_e2_guess", guess, 3'b001);
    applyStimulus(0, 0);
    checkOutput("t0_e3_guess", guess, 3'b000);
    checkOutput("t0_e3_busy_done", {busy, done}, 2'b10);
    applyStimulus(0, 0);
    checkOutput("t0_e4_done", done, 1);
    checkOutput("t0_e4_found_result", {found, result}, {1'b1, 3'b000});

    $display("[TB] target 7");
    target = 3'd7;
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    checkOutput("t7_e1_guess", guess, 3'b110);
    applyStimulus(0, 0);
    checkOutput("t7_e2_guess", guess, 3'b111);
    applyStimulus(0, 0);
    checkOutput("t7_e3_done_found", {done, found}, 2'b11);
    checkOutput("t7_e3_result", result, 3'b111);

    $display("[TB] comparator stuck at gt");
    mode = 1;
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    checkOutput("gt_e1_guess", guess, 3'b110);
    applyStimulus(0, 0);
    checkOutput("gt_e2_guess", guess, 3'b111);
    applyStimulus(0, 0);
    checkOutput("gt_e3_done", done, 0);
    applyStimulus(0, 0);
    checkOutput("gt_e4_done_busy", {done, busy}, 2'b10);
    checkOutput("gt_e4_found_err", {found, err}, 2'b00);
    checkOutput("gt_e4_result", result, 3'b111);
    mode = 0;

    $display("[TB] reset mid-search");
    target = 3'd5;
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    checkOutput("rst_mid_outputs", {busy, done, found, err}, 4'b0000);
    checkOutput("rst_mid_guess_result", {guess, result}, 6'b0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("rst_mid_no_done", {done, busy}, 2'b00);

    $display("[TB] start on done cycle");
    target = 3'd4;
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    checkOutput("back_e1_done", done, 1);
    applyStimulus(1, 0);
    checkOutput("back_restart_busy", {busy, done}, 2'b10);
    checkOutput("back_restart_guess", guess, 3'b100);
    applyStimulus(0, 0);
    checkOutput("back_second_done", {done, found, result}, {2'b11, 3'b100});

    $display("[TB] illegal flags 011");
    mode = 2;
    applyStimulus(1, 0);
    mode = 2;
    applyStimulus(0, 0);
    checkOutput("oh_done_busy", {done, busy}, 2'b10);
    checkOutput("oh_result", result, 3'b100);
`ifdef SAR_ONEHOT_CHECK_EN
    checkOutput("oh_found_err", {found, err}, 2'b01);
`else
    checkOutput("oh_found_err", {found, err}, 2'b10);
`endif
    mode = 0;
    applyStimulus(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
